// File: rtl/irq_pkg.sv
// Shared types and sizes for the 8-source interrupt priority controller.
package irq_pkg;
    localparam int NUM_SRC = 8;
    localparam int ID_W    = 3;

    typedef logic [ID_W-1:0] irq_id_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;
endpackage

// File: rtl/prio_enc8.sv
// Highest-bit-first priority encoder: bit 7 wins, ID = 7 - bit.
module prio_enc8
    import irq_pkg::*;
(
    input  logic [NUM_SRC-1:0] vec,
    output irq_id_t            id,
    output logic               valid
);
    always_comb begin
        id    = '0;
        valid = |vec;
        // Ascending scan so the highest set bit is the last write.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (vec[i]) id = irq_id_t'(NUM_SRC - 1 - i);
        end
    end
endmodule

// File: rtl/irq_prio_ctrl.sv
// Pending-latch interrupt controller: arbitrate, offer one ID, hold it in service until EOI.
module irq_prio_ctrl
    import irq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] mask,
    output logic               irq_valid,
    output irq_id_t            irq_id,
    input  logic               irq_ready,
    input  logic               eoi,
    output logic               busy,
    output logic [NUM_SRC-1:0] pending
);
    irq_state_e         state, state_nxt;
    irq_id_t            enc_id;
    logic               enc_valid;
    logic [NUM_SRC-1:0] clr;
    logic               accept;

    prio_enc8 u_enc (
        .vec   (pending & mask),
        .id    (enc_id),
        .valid (enc_valid)
    );

    assign accept = (state == OFFER) && irq_ready;

    always_comb begin
        clr = '0;
        // For a 3-bit ID, 7 - id is simply the bitwise complement.
        if (accept) clr[~irq_id] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enc_valid) state_nxt = OFFER;
            OFFER:   if (irq_ready) state_nxt = SERVICE;
            SERVICE: if (eoi)       state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            irq_id    <= '0;
            irq_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            // Set beats clear when the accepted source requests again.
            pending   <= (pending & ~clr) | req;
            if (state == IDLE && enc_valid) irq_id <= enc_id;
            irq_valid <= (state_nxt == OFFER);
            busy      <= (state_nxt == SERVICE);
        end
    end
endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Directed bench for irq_prio_ctrl with hand-computed expectations.
module tb_irq_prio_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req, mask;
    logic       irq_valid, irq_ready, eoi, busy;
    logic [2:0] irq_id;
    logic [7:0] pending;
    int         n_cmp = 0;
    int         n_err = 0;
    logic       seen_valid;

    irq_prio_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mask      (mask),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .irq_ready (irq_ready),
        .eoi       (eoi),
        .busy      (busy),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; mask = 8'hFF; irq_ready = 1'b0; eoi = 1'b0;
        step(); step();
        chk("rst_pending", pending, 8'h00);
        chk("rst_valid", {7'd0, irq_valid}, 8'd0);
        chk("rst_id", {5'd0, irq_id}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        rst_n = 1'b1;

        // single request
        irq_ready = 1'b1; req = 8'h04; step(); req = 8'h00;
        chk("t1_pend_set", pending, 8'h04);
        chk("t1_no_valid_yet", {7'd0, irq_valid}, 8'd0);
        step();
        chk("t1_valid", {7'd0, irq_valid}, 8'd1);
        chk("t1_id", {5'd0, irq_id}, 8'd5);
        step();
        chk("t1_busy", {7'd0, busy}, 8'd1);
        chk("t1_valid_drop", {7'd0, irq_valid}, 8'd0);
        chk("t1_pend_clr", pending, 8'h00);
        eoi = 1'b1; step(); eoi = 1'b0;
        chk("t1_eoi_idle", {7'd0, busy}, 8'd0);
        chk("t1_id_hold", {5'd0, irq_id}, 8'd5);

        // priority
        req = 8'h81; step(); req = 8'h00; step();
        chk("t2_id_first", {5'd0, irq_id}, 8'd0);
        step();
        chk("t2_pend_mid", pending, 8'h01);
        eoi = 1'b1; step(); eoi = 1'b0;
        step();
        chk("t2_valid_second", {7'd0, irq_valid}, 8'd1);
        chk("t2_id_second", {5'd0, irq_id}, 8'd7);
        step();
        chk("t2_pend_end", pending, 8'h00);
        eoi = 1'b1; step(); eoi = 1'b0;

        // no preemption
        irq_ready = 1'b0;
        req = 8'h08; step(); req = 8'h00; step();
        chk("t3_id4", {5'd0, irq_id}, 8'd4);
        req = 8'h80; step(); req = 8'h00;
        chk("t3_pend_both", pending, 8'h88);
        step();
        chk("t3_id_kept", {5'd0, irq_id}, 8'd4);
        chk("t3_valid_kept", {7'd0, irq_valid}, 8'd1);
        irq_ready = 1'b1; step(); irq_ready = 1'b0;
        chk("t3_busy", {7'd0, busy}, 8'd1);
        chk("t3_pend", pending, 8'h80);
        eoi = 1'b1; step(); eoi = 1'b0; step();
        chk("t3_id0", {5'd0, irq_id}, 8'd0);
        irq_ready = 1'b1; step(); irq_ready = 1'b0;
        eoi = 1'b1; step(); eoi = 1'b0;

        // mask
        mask = 8'hFD; req = 8'h02; step(); req = 8'h00;
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen_valid |= irq_valid;
        end
        chk("t4_masked_novalid", {7'd0, seen_valid}, 8'd0);
        chk("t4_pend", pending, 8'h02);
        mask = 8'hFF; step(); step();
        chk("t4_valid", {7'd0, irq_valid}, 8'd1);
        chk("t4_id6", {5'd0, irq_id}, 8'd6);
        irq_ready = 1'b1; step();
        eoi = 1'b1; step(); eoi = 1'b0;

        // set wins over clear
        req = 8'h08; step(); step();
        chk("t5_id4", {5'd0, irq_id}, 8'd4);
        step();
        chk("t5_busy", {7'd0, busy}, 8'd1);
        chk("t5_pend_kept", pending, 8'h08);
        req = 8'h00; eoi = 1'b1; step(); eoi = 1'b0; step();
        chk("t5_reoffer", {5'd0, irq_id}, 8'd4);
        chk("t5_reoffer_valid", {7'd0, irq_valid}, 8'd1);
        step();
        chk("t5_pend_end", pending, 8'h00);
        eoi = 1'b1; step(); eoi = 1'b0;

        // reset mid-service
        req = 8'h10; step(); req = 8'h00; step(); step();
        chk("t6_busy", {7'd0, busy}, 8'd1);
        rst_n = 1'b0; req = 8'hFF; step(); rst_n = 1'b1; req = 8'h00;
        chk("t6_rst_busy", {7'd0, busy}, 8'd0);
        chk("t6_rst_valid", {7'd0, irq_valid}, 8'd0);
        chk("t6_rst_pend", pending, 8'h00);
        chk("t6_rst_id", {5'd0, irq_id}, 8'd0);
        eoi = 1'b1; step(); eoi = 1'b0;
        chk("t6_eoi_ignored_busy", {7'd0, busy}, 8'd0);
        chk("t6_eoi_ignored_valid", {7'd0, irq_valid}, 8'd0);
        irq_ready = 1'b0; req = 8'h20; step(); req = 8'h00;
        chk("t6_capture", pending, 8'h20);
        step();
        chk("t6_offer_id2", {5'd0, irq_id}, 8'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/irq_prio_ctrl.md
IRQ_PRIO_CTRL -- requirements
Module: irq_prio_ctrl

Interface
REQ-001 The block SHALL have no parameters; the source count is fixed at 8 and the ID width at 3.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 req  input  8  request lines, sampled every cycle; a high bit marks that source pending.
REQ-005 mask  input  8  enable per source, 1 = eligible for offer.
REQ-006 irq_valid  output  1  an interrupt ID is being offered.
REQ-007 irq_id  output  3  offered ID; source bit 7 maps to ID 0 and bit 0 maps to ID 7 (ID = 7 - bit).
REQ-008 irq_ready  input  1  consumer accepts the offer when it is high together with irq_valid.
REQ-009 eoi  input  1  end-of-interrupt pulse from the consumer.
REQ-010 busy  output  1  an accepted interrupt is in service.
REQ-011 pending  output  8  registered pending-bit vector.

Function
REQ-012 A pending bit SHALL be set at the edge where its req bit is sampled high, and SHALL stay set until its ID is accepted.
REQ-013 The FSM SHALL have exactly 3 states: IDLE, OFFER and SERVICE.
REQ-014 In IDLE, if (pending & mask) != 0, the FSM SHALL register irq_id from the highest-priority eligible bit and move to OFFER.
- Priority order: bit 7 is highest.
- If no bit is eligible, the FSM SHALL stay in IDLE.
REQ-015 irq_valid SHALL be high exactly in OFFER; busy SHALL be high exactly in SERVICE.
REQ-016 Offer latency: req sampled high at edge k with the FSM idle and the bit unmasked -> irq_valid high after edge k+1.
REQ-017 While irq_valid is high, irq_id SHALL stay constant.
- Applies even if a higher-priority request arrives.
- Applies even if mask changes or the offered bit becomes masked; there is no withdrawal.
REQ-018 On an edge with irq_valid && irq_ready, the block SHALL clear pending[7 - irq_id] and the FSM SHALL move to SERVICE.
REQ-019 If req for the bit being cleared is high on that same edge, set SHALL win and the bit SHALL remain pending.
REQ-020 In SERVICE, eoi high SHALL move the FSM to IDLE at that edge; re-arbitration starts in the following cycle.
REQ-021 The block SHALL ignore eoi outside SERVICE and irq_ready outside OFFER.
REQ-022 Pending bits SHALL keep accumulating in every state, including masked sources.
- A masked pending bit becomes eligible once it is unmasked.
REQ-023 irq_id SHALL hold its last value when irq_valid is low.

Reset
REQ-024 While rst_n is low at a rising edge, the block SHALL set:
- FSM to IDLE;
- pending = 8'h00, irq_valid = 0, irq_id = 3'b000, busy = 0.
REQ-025 Reset asserted mid-OFFER or mid-SERVICE SHALL abandon the transaction with no further handshake.
REQ-026 Requests sampled during reset SHALL be discarded.
REQ-027 In the first cycle after reset release, the block SHALL capture req normally.

Structure
REQ-028 A shared package irq_pkg SHALL hold:
- the FSM state enum (IDLE, OFFER, SERVICE);
- NUM_SRC = 8 and ID_W = 3;
- the ID type.
REQ-029 The highest-priority-first encoding SHALL live in a combinational sub-module prio_enc8.
- Inputs: 8-bit vector. Outputs: 3-bit ID and a valid flag.
- ID is undefined when the input is zero.
- It SHALL be instantiated once on pending & mask.
REQ-030 All outputs SHALL be driven from registers except pending, which is the register itself.

Verification
REQ-031 Single request: req=8'h04 for 1 cycle, mask=8'hFF, irq_ready=1 -> irq_valid=1, irq_id=3'd5 two edges later; next edge busy=1, pending=8'h00.
REQ-032 Priority: req=8'h81 together -> first offer ID 0; after eoi -> offer ID 7; pending ends at 8'h00.
REQ-033 No preemption: offer ID 4 (bit 3) with irq_ready=0, then raise req=8'h80 -> irq_id stays 4 until accepted; after eoi, ID 0 is offered.
REQ-034 Mask: req=8'h02 with mask=8'hFD -> no irq_valid for 10 cycles and pending=8'h02; then mask=8'hFF -> irq_id=6 two edges later.
REQ-035 Set-wins: req[3] held high while ID 4 is accepted -> pending[3] stays 1; after eoi, ID 4 is offered again.
REQ-036 Reset mid-SERVICE: rst_n=0 for 1 cycle -> busy=0, irq_valid=0, pending=8'h00 next edge; a following eoi has no effect.
